// File: rtl/pc_sequencer.sv
// Program counter, branch-condition latch and return-address logic for the 16-bit multi-cycle core.
// Define PC_RAS_EN to build the hardware return-address stack; otherwise RET takes its address from RegRetAddr.
module pc_sequencer #(
  parameter int                DATA_W    = 16,
  parameter int                RAS_DEPTH = 8,
  parameter logic [DATA_W-1:0] RESET_PC  = '0
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        PcWrite,
  input  logic [1:0]                  PcSource,
  input  logic                        CtrlBranch,
  input  logic                        CTRLRET,
  input  logic                        CallPush,
  input  logic [2:0]                  BrCond,
  input  logic                        Zero,
  input  logic                        Neg,
  input  logic [DATA_W-1:0]           SeqPc,
  input  logic [DATA_W-1:0]           BranchTarget,
  input  logic [DATA_W-1:0]           JumpTarget,
  input  logic [DATA_W-1:0]           RegRetAddr,
  output logic [DATA_W-1:0]           Pc,
  output logic [DATA_W-1:0]           RetAddr,
  output logic                        Taken,
  output logic [$clog2(RAS_DEPTH):0]  RasCount,
  output logic                        RasOverflow,
  output logic                        RasUnderflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] SRC_SEQ    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;
  localparam logic [1:0] SRC_RET    = 2'b11;

  logic [DATA_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] ret_addr_reg;
  logic [2:0]        cond_reg;
  logic              taken;

  // Conditions come in pairs (register compare / compare-with-zero); bit 0 doesn't change the flag test.
  always_comb begin
    taken = 1'b0;
    case (cond_reg[2:1])
      2'd0:    taken = !Zero && !Neg;
      2'd1:    taken = Neg;
      2'd2:    taken = Zero;
      default: taken = !Zero;
    endcase
  end

  // A branch select only moves the PC when taken, even if PcWrite is also asserted.
  always_comb begin
    pc_next = pc_reg;
    case (PcSource)
      SRC_SEQ:    if (PcWrite) pc_next = SeqPc;
      SRC_BRANCH: if (taken)   pc_next = BranchTarget;
      SRC_JUMP:   if (PcWrite) pc_next = JumpTarget;
      default:    if (PcWrite) pc_next = ret_addr_reg;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_reg   <= RESET_PC;
      cond_reg <= 3'd0;
    end else begin
      pc_reg <= pc_next;
      if (CtrlBranch) cond_reg <= BrCond;
    end
  end

`ifdef PC_RAS_EN
  logic [DATA_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_reg, ptr_next, top_idx, wr_idx;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              overflow_reg, underflow_reg;
  logic              overflow_set, underflow_set;
  logic              wr_en, ras_empty, ras_full;
  logic              unused_reg_ret;

  assign unused_reg_ret = ^RegRetAddr;

  assign top_idx   = ptr_reg - PTR_W'(1);
  assign ras_empty = (count_reg == '0);
  assign ras_full  = (count_reg == CNT_W'(RAS_DEPTH));

  // Push+pop on a non-empty stack swaps the top entry in place; on an empty
  // stack the pop underflows and the push then proceeds as a normal push.
  always_comb begin
    ptr_next      = ptr_reg;
    count_next    = count_reg;
    wr_en         = 1'b0;
    wr_idx        = ptr_reg;
    overflow_set  = 1'b0;
    underflow_set = 1'b0;
    if (CallPush && CTRLRET && !ras_empty) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else begin
      if (CTRLRET) begin
        if (ras_empty) begin
          underflow_set = 1'b1;
        end else begin
          ptr_next   = top_idx;
          count_next = count_reg - CNT_W'(1);
        end
      end
      if (CallPush) begin
        wr_en    = 1'b1;
        wr_idx   = ptr_reg;
        ptr_next = ptr_reg + PTR_W'(1);
        if (ras_full) overflow_set = 1'b1;
        else          count_next   = count_next + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_reg       <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      ret_addr_reg  <= RESET_PC;
    end else begin
      ptr_reg       <= ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_reg | overflow_set;
      underflow_reg <= underflow_reg | underflow_set;
      if (CTRLRET) ret_addr_reg <= ras_empty ? RESET_PC : ras_mem[top_idx];
    end
  end

  // Storage has no reset so it can map onto RAM; only pointer and count are cleared.
  always_ff @(posedge Clk) begin
    if (wr_en && !Reset) ras_mem[wr_idx] <= pc_reg;
  end

  assign RasCount     = count_reg;
  assign RasOverflow  = overflow_reg;
  assign RasUnderflow = underflow_reg;
`else
  logic unused_call_push;

  assign unused_call_push = CallPush;

  always_ff @(posedge Clk) begin
    if (Reset)        ret_addr_reg <= RESET_PC;
    else if (CTRLRET) ret_addr_reg <= RegRetAddr;
  end

  assign RasCount     = '0;
  assign RasOverflow  = 1'b0;
  assign RasUnderflow = 1'b0;
`endif

  assign Pc      = pc_reg;
  assign RetAddr = ret_addr_reg;
  assign Taken   = taken;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized cycles against a queue-based model.
module tb_pc_sequencer;
  localparam int          DW  = 16;
  localparam int          D   = 8;
  localparam logic [15:0] RPC = 16'h0040;

  logic          Clk, Reset, PcWrite, CtrlBranch, CTRLRET, CallPush, Zero, Neg;
  logic [1:0]    PcSource;
  logic [2:0]    BrCond;
  logic [DW-1:0] SeqPc, BranchTarget, JumpTarget, RegRetAddr;
  logic [DW-1:0] Pc, RetAddr;
  logic          Taken, RasOverflow, RasUnderflow;
  logic [3:0]    RasCount;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_pc, m_ret;
  logic [2:0]  m_cond;
  logic [15:0] m_q[$];
  bit          m_ovf, m_unf;

  pc_sequencer #(.DATA_W(DW), .RAS_DEPTH(D), .RESET_PC(RPC)) dut (
    .Clk(Clk), .Reset(Reset), .PcWrite(PcWrite), .PcSource(PcSource),
    .CtrlBranch(CtrlBranch), .CTRLRET(CTRLRET), .CallPush(CallPush),
    .BrCond(BrCond), .Zero(Zero), .Neg(Neg), .SeqPc(SeqPc),
    .BranchTarget(BranchTarget), .JumpTarget(JumpTarget), .RegRetAddr(RegRetAddr),
    .Pc(Pc), .RetAddr(RetAddr), .Taken(Taken), .RasCount(RasCount),
    .RasOverflow(RasOverflow), .RasUnderflow(RasUnderflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Branch decision from the mnemonic meaning of each condition code.
  function automatic bit model_taken(logic [2:0] c, bit z, bit n);
    case (c)
      3'd0, 3'd1: return !z && !n;   // greater than
      3'd2, 3'd3: return n;          // less than
      3'd4, 3'd5: return z;          // equal
      default:    return !z;         // not equal
    endcase
  endfunction

  task automatic clear_inputs();
    Reset = 0; PcWrite = 0; PcSource = 0; CtrlBranch = 0; CTRLRET = 0; CallPush = 0;
    BrCond = 0; Zero = 0; Neg = 0; SeqPc = 0; BranchTarget = 0; JumpTarget = 0; RegRetAddr = 0;
  endtask

  // Advance one clock, updating the model from the inputs applied before the edge.
  task automatic tick();
    logic [15:0] npc;
    npc = m_pc;
    if (PcSource == 2'b01) begin
      if (model_taken(m_cond, Zero, Neg)) npc = BranchTarget;
    end else if (PcWrite) begin
      npc = (PcSource == 2'b00) ? SeqPc : (PcSource == 2'b10) ? JumpTarget : m_ret;
    end
`ifdef PC_RAS_EN
    if (CTRLRET && CallPush && m_q.size() > 0) begin
      m_ret = m_q[m_q.size()-1];
      m_q[m_q.size()-1] = m_pc;
    end else begin
      if (CTRLRET) begin
        if (m_q.size() == 0) begin m_ret = RPC; m_unf = 1; end
        else m_ret = m_q.pop_back();
      end
      if (CallPush) begin
        if (m_q.size() == D) begin void'(m_q.pop_front()); m_ovf = 1; end
        m_q.push_back(m_pc);
      end
    end
`else
    if (CTRLRET) m_ret = RegRetAddr;
`endif
    if (CtrlBranch) m_cond = BrCond;
    m_pc = npc;
    if (Reset) begin
      m_pc = RPC; m_ret = RPC; m_cond = 0; m_q.delete(); m_ovf = 0; m_unf = 0;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset = 1;
    tick();
    tick();
    Reset = 0;
    n_checks++; if (Pc !== 16'h0040) $display("FAIL reset_pc got %h want %h", Pc, 16'h0040); else n_pass++;
    n_checks++; if (RetAddr !== 16'h0040) $display("FAIL reset_ret got %h want %h", RetAddr, 16'h0040); else n_pass++;
    n_checks++; if (RasCount !== 4'd0) $display("FAIL reset_count got %0d want 0", RasCount); else n_pass++;
    n_checks++; if ({RasOverflow, RasUnderflow} !== 2'b00) $display("FAIL reset_flags got %b want 00", {RasOverflow, RasUnderflow}); else n_pass++;
    Zero = 0; Neg = 0; #1;
    n_checks++; if (Taken !== 1'b1) $display("FAIL reset_taken_gt got %b want 1", Taken); else n_pass++;
    Neg = 1; #1;
    n_checks++; if (Taken !== 1'b0) $display("FAIL reset_taken_gt_neg got %b want 0", Taken); else n_pass++;
    $display("reset: Pc=%h RetAddr=%h RasCount=%0d", Pc, RetAddr, RasCount);
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      PcWrite = 1; PcSource = 2'b00; SeqPc = Pc + 16'd1;
      tick();
      n_checks++; if (Pc !== 16'h0041 + 16'(i)) $display("FAIL fetch%0d got %h want %h", i, Pc, 16'h0041 + 16'(i)); else n_pass++;
      $display("fetch %0d: Pc=%h", i, Pc);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    CtrlBranch = 1; BrCond = 3'd4;
    tick();
    clear_inputs();
    Zero = 1; PcSource = 2'b01; BranchTarget = 16'h0100; #1;
    n_checks++; if (Taken !== 1'b1) $display("FAIL beq_taken got %b want 1", Taken); else n_pass++;
    tick();
    n_checks++; if (Pc !== 16'h0100) $display("FAIL beq_pc got %h want 0100", Pc); else n_pass++;
    $display("branch taken: Pc=%h", Pc);
    Zero = 0; PcWrite = 1; BranchTarget = 16'h0300; #1;
    n_checks++; if (Taken !== 1'b0) $display("FAIL beq_not_taken got %b want 0", Taken); else n_pass++;
    tick();
    n_checks++; if (Pc !== 16'h0100) $display("FAIL beq_hold got %h want 0100", Pc); else n_pass++;
    $display("branch not taken: Pc=%h", Pc);
    // condition stays latched until the next strobe
    clear_inputs();
    BrCond = 3'd2; Zero = 1; #1;
    n_checks++; if (Taken !== 1'b1) $display("FAIL cond_held got %b want 1", Taken); else n_pass++;
  endtask

`ifdef PC_RAS_EN
  task automatic test_call_ret();
    clear_inputs();
    PcWrite = 1; PcSource = 2'b10; JumpTarget = 16'h0020;
    tick();
    clear_inputs();
    CallPush = 1;
    tick();
    n_checks++; if (RasCount !== 4'd1) $display("FAIL call_count got %0d want 1", RasCount); else n_pass++;
    clear_inputs();
    PcWrite = 1; PcSource = 2'b10; JumpTarget = 16'h0200;
    tick();
    n_checks++; if (Pc !== 16'h0200) $display("FAIL call_pc got %h want 0200", Pc); else n_pass++;
    clear_inputs();
    CTRLRET = 1;
    tick();
    n_checks++; if (RetAddr !== 16'h0020) $display("FAIL ret_addr got %h want 0020", RetAddr); else n_pass++;
    n_checks++; if (RasCount !== 4'd0) $display("FAIL ret_count got %0d want 0", RasCount); else n_pass++;
    clear_inputs();
    PcWrite = 1; PcSource = 2'b11;
    tick();
    n_checks++; if (Pc !== 16'h0020) $display("FAIL ret_pc got %h want 0020", Pc); else n_pass++;
    $display("call/ret: Pc=%h RetAddr=%h RasCount=%0d", Pc, RetAddr, RasCount);
  endtask

  task automatic test_overflow();
    clear_inputs();
    PcWrite = 1; PcSource = 2'b10; JumpTarget = 16'h0001;
    tick();
    for (int i = 1; i <= 9; i++) begin
      clear_inputs();
      CallPush = 1; PcWrite = 1; PcSource = 2'b10; JumpTarget = 16'(i + 1);
      tick();
    end
    n_checks++; if (RasCount !== 4'd8) $display("FAIL ovf_count got %0d want 8", RasCount); else n_pass++;
    n_checks++; if (RasOverflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", RasOverflow); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      clear_inputs();
      CTRLRET = 1;
      tick();
      n_checks++; if (RetAddr !== 16'(9 - k)) $display("FAIL ovf_pop%0d got %h want %h", k, RetAddr, 16'(9 - k)); else n_pass++;
      $display("pop %0d: RetAddr=%h RasCount=%0d", k, RetAddr, RasCount);
    end
  endtask

  task automatic test_underflow();
    clear_inputs();
    CTRLRET = 1;
    tick();
    n_checks++; if (RetAddr !== RPC) $display("FAIL unf_ret got %h want %h", RetAddr, RPC); else n_pass++;
    n_checks++; if (RasUnderflow !== 1'b1) $display("FAIL unf_flag got %b want 1", RasUnderflow); else n_pass++;
    n_checks++; if (RasCount !== 4'd0) $display("FAIL unf_count got %0d want 0", RasCount); else n_pass++;
    clear_inputs();
    CallPush = 1;
    tick();
    clear_inputs();
    tick();
    n_checks++; if (RasUnderflow !== 1'b1) $display("FAIL unf_sticky got %b want 1", RasUnderflow); else n_pass++;
    $display("underflow: RetAddr=%h RasUnderflow=%b", RetAddr, RasUnderflow);
  endtask
`else
  task automatic test_reg_ret();
    clear_inputs();
    CTRLRET = 1; RegRetAddr = 16'h1234;
    tick();
    n_checks++; if (RetAddr !== 16'h1234) $display("FAIL regret got %h want 1234", RetAddr); else n_pass++;
    clear_inputs();
    CallPush = 1;
    tick();
    n_checks++; if (RasCount !== 4'd0) $display("FAIL regret_count got %0d want 0", RasCount); else n_pass++;
    $display("reg ret: RetAddr=%h", RetAddr);
  endtask
`endif

  task automatic test_ret_same_cycle();
    clear_inputs();
    PcWrite = 1; PcSource = 2'b11; CTRLRET = 1; RegRetAddr = 16'h5555;
    tick();
    n_checks++; if (Pc !== m_pc) $display("FAIL ret_same_cycle_pc got %h want %h", Pc, m_pc); else n_pass++;
    n_checks++; if (RetAddr !== m_ret) $display("FAIL ret_same_cycle_ret got %h want %h", RetAddr, m_ret); else n_pass++;
    $display("pop+ret write: Pc=%h RetAddr=%h", Pc, RetAddr);
  endtask

  task automatic test_reset_mid_call();
    clear_inputs();
    PcWrite = 1; PcSource = 2'b10; JumpTarget = 16'h0077;
    tick();
    clear_inputs();
    CallPush = 1;
    tick();
    clear_inputs();
    Reset = 1; PcWrite = 1; PcSource = 2'b10; JumpTarget = 16'h0999; CallPush = 1;
    tick();
    Reset = 0;
    n_checks++; if (Pc !== RPC) $display("FAIL midcall_pc got %h want %h", Pc, RPC); else n_pass++;
    n_checks++; if (RasCount !== 4'd0) $display("FAIL midcall_count got %0d want 0", RasCount); else n_pass++;
    n_checks++; if ({RasOverflow, RasUnderflow} !== 2'b00) $display("FAIL midcall_flags got %b want 00", {RasOverflow, RasUnderflow}); else n_pass++;
    $display("reset mid-call: Pc=%h RasCount=%0d", Pc, RasCount);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clear_inputs();
      Reset        = ($urandom_range(0, 59) == 0);
      PcWrite      = $urandom_range(0, 1);
      PcSource     = 2'($urandom_range(0, 3));
      CtrlBranch   = ($urandom_range(0, 3) == 0);
      CTRLRET      = ($urandom_range(0, 3) == 0);
      CallPush     = ($urandom_range(0, 2) == 0);
      BrCond       = 3'($urandom_range(0, 7));
      Zero         = $urandom_range(0, 1);
      Neg          = $urandom_range(0, 1);
      SeqPc        = 16'($urandom);
      BranchTarget = 16'($urandom);
      JumpTarget   = 16'($urandom);
      RegRetAddr   = 16'($urandom);
      #1;
      n_checks++; if (Taken !== model_taken(m_cond, Zero, Neg)) $display("FAIL rnd%0d_taken got %b want %b", i, Taken, model_taken(m_cond, Zero, Neg)); else n_pass++;
      tick();
      n_checks++; if (Pc !== m_pc) $display("FAIL rnd%0d_pc got %h want %h", i, Pc, m_pc); else n_pass++;
      n_checks++; if (RetAddr !== m_ret) $display("FAIL rnd%0d_ret got %h want %h", i, RetAddr, m_ret); else n_pass++;
      n_checks++; if (RasCount !== 4'(m_q.size())) $display("FAIL rnd%0d_count got %0d want %0d", i, RasCount, m_q.size()); else n_pass++;
      n_checks++; if ({RasOverflow, RasUnderflow} !== {m_ovf, m_unf}) $display("FAIL rnd%0d_flags got %b want %b", i, {RasOverflow, RasUnderflow}, {m_ovf, m_unf}); else n_pass++;
      $display("rnd %0d: rst=%b src=%0d wr=%b push=%b pop=%b Pc=%h RetAddr=%h cnt=%0d", i, Reset, PcSource, PcWrite, CallPush, CTRLRET, Pc, RetAddr, RasCount);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_branch();
`ifdef PC_RAS_EN
    test_call_ret();
    test_overflow();
    test_underflow();
`else
    test_reg_ret();
`endif
    test_ret_same_cycle();
    test_reset_mid_call();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
